// File: rtl/shift_right_iterative_if.sv
// shift_right_iterative_if: request/result handshake bundle for the iterative right shifter
interface shift_right_iterative_if #(parameter int WIDTH = 32, parameter int SHAMT_W = 5);
  logic               start_i;
  logic [WIDTH-1:0]   data_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic               arith_i;
  logic               ack_i;
  logic               ready_o;
  logic               busy_o;
  logic               valid_o;
  logic [WIDTH-1:0]   result_o;
  modport master (output start_i, data_i, shamt_i, arith_i, ack_i, input ready_o, busy_o, valid_o, result_o);
  modport slave  (input start_i, data_i, shamt_i, arith_i, ack_i, output ready_o, busy_o, valid_o, result_o);
endinterface

// File: rtl/shift_right_iterative.sv
// shift_right_iterative: logical/arithmetic right shift, one bit position per clock
module shift_right_iterative #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic                    clk_i,
  input logic                    rst_i,
  shift_right_iterative_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               arith_q, arith_d;
  logic               accept;
  assign accept = (state_q == IDLE) && bus.start_i;
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    arith_d = arith_q;
    case (state_q)
      IDLE: begin
        sr_d    = accept ? bus.data_i : sr_q;
        cnt_d   = accept ? bus.shamt_i : cnt_q;
        arith_d = accept ? bus.arith_i : arith_q;
        state_d = !accept ? IDLE : (bus.shamt_i == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        sr_d    = {arith_q & sr_q[WIDTH-1], sr_q[WIDTH-1:1]};
        cnt_d   = cnt_q - SHAMT_W'(1);
        state_d = (cnt_q == SHAMT_W'(1)) ? DONE : SHIFT;
      end
      DONE:    state_d = bus.ack_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
    end
  end
  assign bus.ready_o  = (state_q == IDLE);
  assign bus.busy_o   = (state_q == SHIFT) || (state_q == DONE);
  assign bus.valid_o  = (state_q == DONE);
  assign bus.result_o = sr_q;
endmodule

// File: doc/shift_right_iterative.md
# shift_right_iterative

Sequential right-shift unit for the datapath: the counterpart of the existing fixed left-shift logic. It performs logical (SRL/SRLV) or arithmetic (SRA/SRAV) right shifts by a variable amount, one bit position per clock cycle. Operands are accepted through a ready/start handshake, and the result is held under a valid/ack handshake. It sits beside the ALU and serves shift instructions when a full combinational barrel shifter is not wanted.

## Interface
- Parameters
  - `WIDTH`, 32, data width in bits.
  - `SHAMT_W`, 5, shift-amount width; maximum shift is 2^SHAMT_W − 1.
- Ports
  - `clk_i`  in  1  clock; all state updates on the rising edge.
  - `rst_i`  in  1  reset, synchronous, active-low.
  - `start_i`  in  1  request; accepted only on a rising edge where `start_i`=1 and `ready_o`=1.
  - `data_i`  in  WIDTH  operand; sampled at accept.
  - `shamt_i`  in  SHAMT_W  shift amount, unsigned; sampled at accept.
  - `arith_i`  in  1  1 = arithmetic (sign fill), 0 = logical (zero fill); sampled at accept.
  - `ready_o`  out  1  high only in IDLE.
  - `busy_o`  out  1  high in SHIFT and DONE.
  - `valid_o`  out  1  high only in DONE; `result_o` is meaningful only while this is high.
  - `result_o`  out  WIDTH  shift result; registered.
  - `ack_i`  in  1  consumer acknowledge; sampled only while `valid_o`=1.

## Operation
- Reset: on a rising edge with `rst_i`=0, the block enters IDLE.
  - Reset outputs: `ready_o`=1, `busy_o`=0, `valid_o`=0, `result_o`=0.
  - Internal state cleared: shift register 0, counter 0, latched mode 0.
  - Reset overrides any in-flight operation, including one in DONE; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE
  - On accept, load the shift register with `data_i`, the counter with `shamt_i`, and latch `arith_i`.
  - If `shamt_i`=0, go to DONE; otherwise go to SHIFT.
  - If `start_i`=0, stay in IDLE.
- SHIFT
  - Each edge: shift register ← shift register >> 1.
  - The vacated MSB is filled with the current MSB when latched mode=1, and with 0 when latched mode=0.
  - Counter decrements by 1 each edge.
  - When the counter goes 1→0, go to DONE in the same edge.
- DONE
  - `result_o` presents the shift register.
  - `result_o` and `valid_o` hold stable until the edge where `ack_i`=1; that edge returns the block to IDLE.
- Changes to `start_i`, `data_i`, `shamt_i` or `arith_i` outside the accept edge have no effect, including while `busy_o`=1.
- Arithmetic rules
  - The result equals `data_i` >> `shamt_i` (logical) or `data_i` >>> `shamt_i` (arithmetic), truncated to WIDTH.
  - A logical shift by WIDTH−1 of an MSB-set operand yields 1.
  - An arithmetic shift of a negative operand by WIDTH−1 yields all ones.
  - Arithmetic mode with MSB=0 is identical to logical mode.

## Timing
- Let E0 be the accept edge.
  - `valid_o` first goes high after edge E0+`shamt_i`.
  - `shamt_i`=0: `valid_o` is high in the cycle right after E0 (1-cycle pass-through).
  - `shamt_i`=31: `valid_o` goes high after E31.
- `ready_o` drops after E0 and rises after the ack edge.
  - No new request is accepted in the ack cycle itself.
  - Minimum request spacing is `shamt_i`+2 cycles.
- `ack_i` asserted together with the first `valid_o` cycle is honoured; `valid_o` is then high for exactly one cycle.
- `ack_i` while not in DONE is ignored.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.

## Test plan
- SRL: `data_i`=0x80000000, `shamt_i`=4, `arith_i`=0, `ack_i`=1 → `valid_o` high only in the cycle after E4, `result_o`=0x08000000, then `ready_o`=1.
- SRA: `data_i`=0x80000000, `shamt_i`=31, `arith_i`=1 → `result_o`=0xFFFFFFFF after E31. Repeat with `arith_i`=0 → `result_o`=0x00000001.
- Zero shift: `data_i`=0xDEADBEEF, `shamt_i`=0 → `valid_o` in the cycle after E0, `result_o`=0xDEADBEEF.
- Ignore while busy: accept 0x0000F000 with `shamt_i`=8; at E3 drive `start_i`=1 with 0xFFFFFFFF → `result_o`=0x000000F0; no second accept until `ready_o` returns.
- Back-pressure: hold `ack_i`=0 for 5 cycles in DONE → `valid_o` and `result_o` stable; assert `ack_i` → IDLE next edge.
- Reset mid-shift: `rst_i`=0 at E2 of an 8-bit shift → next cycle `ready_o`=1, `valid_o`=0, `result_o`=0; a fresh request then completes normally.
